fp_unpack32: RTL
================

// Module: fp_unpack32
// PURPOSE
//  Front-end unpacker: inverse of the FPU normalization stage. Converts a packed IEEE 754
//  binary32 operand into the expanded internal form: hidden bit explicit, denormals
//  pre-normalized by widening the exponent, class flags decoded. Feeds the add/mul/div cores.
//  Three-stage pipeline with clock enable and valid tracking.
// PARAMETERS
//  DAZ  1'b0  1 = denormals-are-zero: denormal input yields signed zero (denorm_o still set)
// PORTS
//  clk       in   1    clock
//  rst       in   1    synchronous active-high reset
//  ce        in   1    pipeline advance enable; all stages hold when low
//  vld_i     in   1    i carries a valid operand this cycle
//  i         in   32   packed binary32 {sign, exp[7:0], frac[22:0]}
//  vld_o     out  1    outputs valid
//  sign_o    out  1    sign, passed through unchanged
//  exp_o     out  10   signed two's-complement biased exponent (bias 127)
//  sig_o     out  24   significand, bit 23 = explicit leading one
//  zero_o    out  1    input was +/-0 (or a denormal with DAZ=1)
//  denorm_o  out  1    input exp field 0 and frac != 0
//  inf_o     out  1    input was +/-infinity
//  qnan_o    out  1    quiet NaN (exp 255, frac[22]=1)
//  snan_o    out  1    signalling NaN (exp 255, frac[22]=0, frac != 0)
// BEHAVIOUR
//  Reset: rst is synchronous, active-high and overrides ce. Clears all pipeline registers
//    including valids. Every output reads 0 the cycle after rst is sampled high.
//    An operand in flight when rst is asserted is discarded.
//  Latency: exactly 3 ce-qualified clock edges from i/vld_i to the outputs; throughput 1/cycle.
//  ce low: no register changes; outputs hold their values; vld_o holds.
//  Invalid slots: data still flows. vld_o is vld_i delayed 3 ce edges; consumers qualify on vld_o.
//  Stage 1: register the fields. Classify:
//    e==0 & f==0 -> zero
//    e==0 & f!=0 -> denorm
//    e==255 & f==0 -> inf
//    e==255 & f!=0 -> NaN, split by f[22]
//  Stage 2: lz = leading-zero count of the 23-bit frac (0..22). Meaningful only for denorm;
//    for other classes lz is forced to 0.
//  Stage 3: form the outputs.
//    normal (1..254): exp_o = e, sig_o = {1'b1, f}
//    denorm, DAZ=0:   sig_o = {1'b0, f} << (lz+1), so bit 23 = 1; exp_o = -lz (range 0..-22)
//    denorm, DAZ=1:   exp_o = 0, sig_o = 0, zero_o = 1, denorm_o = 1
//    zero:            exp_o = 0, sig_o = 0
//    inf:             exp_o = 255, sig_o = 24'h800000
//    NaN:             exp_o = 255, sig_o = {1'b1, f}; payload preserved, no quieting here
//  Exactly one of {zero, inf, qnan, snan, normal} is true per valid output.
//  denorm_o may coexist with zero_o only when DAZ=1.
//  Round trip: feeding exp_o/sig_o (with two whole bits prepended) to the normalizer
//    reproduces i bit-exactly for every non-NaN input.
// TESTING
//  1) rst 1 cycle, then i=32'h3F800000 vld_i=1 ce=1 -> after 3 edges: vld_o=1, exp_o=127,
//     sig_o=24'h800000, all flags 0.
//  2) i=32'h00000001 (min denormal), DAZ=0 -> exp_o=10'h3EA (-22), sig_o=24'h800000,
//     denorm_o=1; with DAZ=1 -> zero_o=1, sig_o=0.
//  3) i=32'h7F800000 -> inf_o=1, exp_o=255; i=32'h7FC00000 -> qnan_o=1;
//     i=32'h7F800001 -> snan_o=1, sig_o=24'h800001.
//  4) i=32'h80000000 -> sign_o=1, zero_o=1, exp_o=0, sig_o=0.
//  5) stream 4 operands with ce toggled 1,0,1,0,... -> outputs advance only on ce edges;
//     ordering preserved; each result appears after its 3rd ce edge.
//  6) rst asserted with 2 operands in flight -> vld_o=0 next cycle; no stale result emerges
//     after rst deasserts.
//  Exhaustive sweep: all 2^23 denormal patterns against a reference model.

Source files
------------

// File: rtl/fp_unpack32_if.sv
// Operand bus for the binary32 unpacker: the packed operand and its valid and
// clock enable going in, the expanded operand and class flags coming out.
interface fp_unpack32_if;
  logic        ce;
  logic        vld_i;
  logic [31:0] i;
  logic        vld_o;
  logic        sign_o;
  logic [9:0]  exp_o;
  logic [23:0] sig_o;
  logic        zero_o;
  logic        denorm_o;
  logic        inf_o;
  logic        qnan_o;
  logic        snan_o;

  // Producer side: drives the operand, consumes the unpacked result
  modport master (
    output ce, vld_i, i,
    input  vld_o, sign_o, exp_o, sig_o, zero_o, denorm_o, inf_o, qnan_o, snan_o
  );

  // Unpacker side
  modport slave (
    input  ce, vld_i, i,
    output vld_o, sign_o, exp_o, sig_o, zero_o, denorm_o, inf_o, qnan_o, snan_o
  );
endinterface

// File: rtl/fp_unpack32.sv
// Binary32 front-end unpacker. Three registered stages:
//   1) split fields and classify, 2) leading-zero count for denormals,
//   3) build exponent/significand (denormals pre-normalized).
// Exponent is a 10-bit two's-complement biased value so denormals can go negative.
module fp_unpack32 #(
  parameter logic DAZ = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  fp_unpack32_if.slave  bus
);

  // Leading zeros of a 23-bit fraction, scanning from the MSB.
  function automatic logic [4:0] lzc23(input logic [22:0] f);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int k = 22; k >= 0; k--) begin
      if (!found) begin
        if (f[k]) begin
          found = 1'b1;
        end else begin
          n = n + 5'd1;
        end
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Stage 1 state
  logic        v1_q, s1_q, zero1_q, den1_q, inf1_q, qnan1_q, snan1_q;
  logic [7:0]  e1_q;
  logic [22:0] f1_q;
  logic        zero1_d, den1_d, inf1_d, qnan1_d, snan1_d;
  // Stage 2 state
  logic        v2_q, s2_q, zero2_q, den2_q, inf2_q, qnan2_q, snan2_q;
  logic [7:0]  e2_q;
  logic [22:0] f2_q;
  logic [4:0]  lz2_q, lz2_d;
  // Stage 3 (output) state
  logic        vld_q, sign_q, zero_q, den_q, inf_q, qnan_q, snan_q;
  logic [9:0]  exp_q, exp_d;
  logic [23:0] sig_q, sig_d;
  logic        zero_d;

  // Classify the incoming operand from its exponent and fraction fields
  always_comb begin
    zero1_d = 1'b0;
    den1_d  = 1'b0;
    inf1_d  = 1'b0;
    qnan1_d = 1'b0;
    snan1_d = 1'b0;
    if (bus.i[30:23] == 8'd0) begin
      if (bus.i[22:0] == 23'd0) begin
        zero1_d = 1'b1;
      end else begin
        den1_d = 1'b1;
      end
    end else if (bus.i[30:23] == 8'd255) begin
      if (bus.i[22:0] == 23'd0) begin
        inf1_d = 1'b1;
      end else if (bus.i[22]) begin
        qnan1_d = 1'b1;
      end else begin
        snan1_d = 1'b1;
      end
    end else begin
      zero1_d = 1'b0;
    end
  end

  // Shift distance only matters for denormals; other classes keep it at zero
  always_comb begin
    if (den1_q) begin
      lz2_d = lzc23(f1_q);
    end else begin
      lz2_d = 5'd0;
    end
  end

  // Build the expanded operand; normal, inf and NaN share {1, f} with exp = e
  always_comb begin
    exp_d  = {2'b00, e2_q};
    sig_d  = {1'b1, f2_q};
    zero_d = zero2_q;
    if (zero2_q) begin
      exp_d = 10'd0;
      sig_d = 24'd0;
    end else if (den2_q) begin
      if (DAZ) begin
        exp_d  = 10'd0;
        sig_d  = 24'd0;
        zero_d = 1'b1;
      end else begin
        exp_d = 10'd0 - {5'd0, lz2_q};
        sig_d = {1'b0, f2_q} << ({1'b0, lz2_q} + 6'd1);
      end
    end else begin
      exp_d = {2'b00, e2_q};
      sig_d = {1'b1, f2_q};
    end
  end

  // Pipeline registers: reset clears everything, otherwise advance only on ce
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0; s1_q <= 1'b0; e1_q <= 8'd0; f1_q <= 23'd0;
      zero1_q <= 1'b0; den1_q <= 1'b0; inf1_q <= 1'b0; qnan1_q <= 1'b0; snan1_q <= 1'b0;
      v2_q <= 1'b0; s2_q <= 1'b0; e2_q <= 8'd0; f2_q <= 23'd0; lz2_q <= 5'd0;
      zero2_q <= 1'b0; den2_q <= 1'b0; inf2_q <= 1'b0; qnan2_q <= 1'b0; snan2_q <= 1'b0;
      vld_q <= 1'b0; sign_q <= 1'b0; exp_q <= 10'd0; sig_q <= 24'd0;
      zero_q <= 1'b0; den_q <= 1'b0; inf_q <= 1'b0; qnan_q <= 1'b0; snan_q <= 1'b0;
    end else if (bus.ce) begin
      v1_q <= bus.vld_i; s1_q <= bus.i[31]; e1_q <= bus.i[30:23]; f1_q <= bus.i[22:0];
      zero1_q <= zero1_d; den1_q <= den1_d; inf1_q <= inf1_d; qnan1_q <= qnan1_d; snan1_q <= snan1_d;
      v2_q <= v1_q; s2_q <= s1_q; e2_q <= e1_q; f2_q <= f1_q; lz2_q <= lz2_d;
      zero2_q <= zero1_q; den2_q <= den1_q; inf2_q <= inf1_q; qnan2_q <= qnan1_q; snan2_q <= snan1_q;
      vld_q <= v2_q; sign_q <= s2_q; exp_q <= exp_d; sig_q <= sig_d;
      zero_q <= zero_d; den_q <= den2_q; inf_q <= inf2_q; qnan_q <= qnan2_q; snan_q <= snan2_q;
    end
  end

  assign bus.vld_o    = vld_q;
  assign bus.sign_o   = sign_q;
  assign bus.exp_o    = exp_q;
  assign bus.sig_o    = sig_q;
  assign bus.zero_o   = zero_q;
  assign bus.denorm_o = den_q;
  assign bus.inf_o    = inf_q;
  assign bus.qnan_o   = qnan_q;
  assign bus.snan_o   = snan_q;

endmodule
